// File: rtl/ctrl_pkt_loader_pkg.sv
// ctrl_pkt_loader_pkg: shared widths, FSM states and header field offsets
package ctrl_pkt_loader_pkg;
    localparam int phit_size = 512;
    localparam int dwidth_RFadd = 8;
    localparam int num_stage = 6;
    localparam int num_entry_state = 2;
    localparam int cnt_w = dwidth_RFadd + 4;
    localparam int nct_lsb = 0;
    localparam int nib_lsb = dwidth_RFadd;
    typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT_DONE, DRAIN} state_t;
endpackage

// File: rtl/ctrl_pkt_loader.sv
// ctrl_pkt_loader: parses a config packet header, replays table words as a gap-free burst, then forwards stream phits
module ctrl_pkt_loader
    import ctrl_pkt_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [phit_size-1:0]    s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic                    start_loader,
    output logic [dwidth_RFadd-1:0] num_entry_config_table,
    output logic [dwidth_RFadd-1:0] num_entry_inbound,
    output logic [phit_size-1:0]    wr_data,
    output logic                    start_stream_in,
    output logic [phit_size-1:0]    stream_data,
    output logic                    stream_valid,
    input  logic                    cp_ready,
    input  logic                    cp_done,
    output logic                    busy,
    output logic                    err
);
    state_t state;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] last_idx;
    logic acc;

    assign acc = s_tvalid && s_tready;
    assign last_idx = cnt_w'(num_entry_state - 1) + cnt_w'(2 * num_stage) * cnt_w'(num_entry_config_table)
                    + cnt_w'(num_entry_inbound);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            s_tready <= 1'b0;
            start_loader <= 1'b0;
            start_stream_in <= 1'b0;
            stream_valid <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
            wr_data <= '0;
            stream_data <= '0;
            num_entry_config_table <= '0;
            num_entry_inbound <= '0;
        end else begin
            start_loader <= 1'b0;
            stream_valid <= 1'b0;
            case (state)
                IDLE: begin
                    s_tready <= 1'b1;
                    if (acc && s_tlast) err <= 1'b1;
                    else if (acc) begin
                        num_entry_config_table <= s_tdata[nct_lsb +: dwidth_RFadd];
                        num_entry_inbound <= s_tdata[nib_lsb +: dwidth_RFadd];
                        cnt <= '0;
                        start_loader <= 1'b1;
                        busy <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!s_tvalid) begin
                        err <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        wr_data <= s_tdata;
                        cnt <= cnt + 1'b1;
                        if (cnt == last_idx && s_tlast) begin
                            s_tready <= 1'b0;
                            state <= WAIT_DONE;
                        end else if (cnt == last_idx) begin
                            s_tready <= cp_ready;
                            start_stream_in <= 1'b1;
                            state <= STREAM;
                        end else if (s_tlast) begin
                            err <= 1'b1;
                            busy <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                STREAM: begin
                    s_tready <= cp_ready;
                    if (acc) begin
                        stream_data <= s_tdata;
                        stream_valid <= 1'b1;
                    end
                    if (acc && s_tlast) begin
                        s_tready <= 1'b0;
                        start_stream_in <= 1'b0;
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (cp_done) begin
                        s_tready <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (acc && s_tlast) begin
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_pkt_loader.sv
// tb_ctrl_pkt_loader: directed vectors against hand-computed expectations
module tb_ctrl_pkt_loader;
    import ctrl_pkt_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [phit_size-1:0] s_tdata = '0;
    logic s_tvalid = 1'b0;
    logic s_tlast = 1'b0;
    logic s_tready;
    logic start_loader;
    logic [dwidth_RFadd-1:0] num_entry_config_table;
    logic [dwidth_RFadd-1:0] num_entry_inbound;
    logic [phit_size-1:0] wr_data;
    logic start_stream_in;
    logic [phit_size-1:0] stream_data;
    logic stream_valid;
    logic cp_ready = 1'b1;
    logic cp_done = 1'b0;
    logic busy;
    logic err;

    ctrl_pkt_loader dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .start_loader(start_loader),
        .num_entry_config_table(num_entry_config_table), .num_entry_inbound(num_entry_inbound),
        .wr_data(wr_data), .start_stream_in(start_stream_in), .stream_data(stream_data),
        .stream_valid(stream_valid), .cp_ready(cp_ready), .cp_done(cp_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int p_cyc = 0;
    logic [phit_size-1:0] wr_log [0:4095];
    logic [phit_size-1:0] sq [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_log[cyc % 4096] = wr_data;
        if (start_loader) begin
            pulses++;
            p_cyc = cyc;
        end
        if (stream_valid) sq.push_back(stream_data);
    end

    task automatic check(input string tag, input logic [phit_size-1:0] got, input logic [phit_size-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [phit_size-1:0] d, input logic l);
        int n = 0;
        s_tdata = d;
        s_tvalid = 1'b1;
        s_tlast = l;
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("tready_wait", {511'd0, s_tready}, 1);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_load(input int from, input int upto, input int lastk, input int base);
        for (int k = from; k < upto; k++) send(phit_size'(base + k), k == lastk);
    endtask

    task automatic check_load(input string tag, input int n, input int base);
        int bad = 0;
        for (int k = 0; k < n; k++)
            if (wr_log[(p_cyc + 1 + k) % 4096] !== phit_size'(base + k)) bad++;
        check(tag, phit_size'(bad), 0);
    endtask

    task automatic check_stream(input string tag, input int n, input int base);
        int bad = 0;
        check({tag, "_len"}, phit_size'(sq.size()), phit_size'(n));
        for (int j = 0; j < n && j < sq.size(); j++)
            if (sq[j] !== phit_size'(base + j)) bad++;
        check(tag, phit_size'(bad), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sq.delete();
    endtask

    task automatic finish_done();
        @(negedge clk);
        cp_done = 1'b1;
        @(negedge clk);
        cp_done = 1'b0;
    endtask

    initial begin
        int bad;
        int p0;
        repeat (2) @(negedge clk);
        check("rst_tready", {511'd0, s_tready}, 0);
        check("rst_busy_err_pulse", {509'd0, busy, err, start_loader}, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_counts", {496'd0, num_entry_config_table, num_entry_inbound}, 0);
        rst_n = 1'b1;

        // full packet, cp_ready held high
        pulses = 0;
        send(phit_size'(16'h1002), 1'b0);
        send_load(0, 42, -1, 0);
        for (int j = 0; j < 16; j++) send(phit_size'('h1000 + j), j == 15);
        @(negedge clk);
        check("t1_pulses", phit_size'(pulses), 1);
        check("t1_counts", {496'd0, num_entry_config_table, num_entry_inbound}, {496'd0, 8'd2, 8'd16});
        check_load("t1_wr_burst", 42, 0);
        check_stream("t1_stream", 16, 'h1000);
        check("t1_wait_state", {508'd0, busy, s_tready, start_stream_in, err}, {508'd0, 4'b1000});
        finish_done();
        check("t1_idle_busy", {511'd0, busy}, 0);

        // stream entry with cp_ready low
        sq.delete();
        cp_ready = 1'b0;
        send(phit_size'(16'h1002), 1'b0);
        send_load(0, 42, -1, 'h200);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (s_tready !== 1'b0 || stream_valid !== 1'b0 || start_stream_in !== 1'b1) bad++;
            @(negedge clk);
        end
        check("t2_backpressure", phit_size'(bad), 0);
        cp_ready = 1'b1;
        for (int j = 0; j < 16; j++) send(phit_size'('h3000 + j), j == 15);
        @(negedge clk);
        check_stream("t2_stream", 16, 'h3000);
        finish_done();

        // s_tvalid drops at load word 10
        sq.delete();
        send(phit_size'(16'h1002), 1'b0);
        send_load(0, 10, -1, 0);
        @(negedge clk);
        check("t3_err", {510'd0, err, busy}, {510'd0, 2'b11});
        send_load(10, 42, -1, 0);
        for (int j = 0; j < 16; j++) send(phit_size'('h1000 + j), j == 15);
        @(negedge clk);
        check("t3_drained", {509'd0, busy, s_tready, stream_valid}, {509'd0, 3'b010});
        check("t3_no_stream", phit_size'(sq.size()), 0);
        p0 = pulses;
        send(phit_size'(16'h0100), 1'b0);
        send_load(0, 3, -1, 'h50);
        send(phit_size'('h77), 1'b1);
        @(negedge clk);
        check("t3_fresh_pulse", phit_size'(pulses - p0), 1);
        check_load("t3_fresh_wr", 3, 'h50);
        check_stream("t3_fresh_stream", 1, 'h77);
        finish_done();

        // early tlast at load word 5
        do_reset();
        send(phit_size'(16'h1002), 1'b0);
        send_load(0, 6, 5, 0);
        @(negedge clk);
        check("t4_err_idle", {508'd0, err, busy, start_stream_in, s_tready}, {508'd0, 4'b1001});
        check("t4_no_stream", phit_size'(sq.size()), 0);

        // nct=0, nib=0: two-word load straight to WAIT_DONE
        do_reset();
        send(phit_size'(16'h0000), 1'b0);
        send_load(0, 2, 1, 'hA0);
        @(negedge clk);
        check_load("t5_wr", 2, 'hA0);
        check("t5_wait_state", {508'd0, busy, s_tready, start_stream_in, err}, {508'd0, 4'b1000});
        finish_done();
        check("t5_idle", {510'd0, busy, s_tready}, {510'd0, 2'b01});

        // header with tlast, then reset mid-load
        do_reset();
        send(phit_size'(16'h0305), 1'b1);
        check("t6_hdr_tlast_err", {510'd0, err, busy}, {510'd0, 2'b10});
        send(phit_size'(16'h1002), 1'b0);
        send_load(0, 5, -1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_flags", {506'd0, s_tready, start_loader, start_stream_in, stream_valid, busy, err}, 0);
        check("t6_rst_wr_data", wr_data, 0);
        check("t6_rst_counts", {496'd0, num_entry_config_table, num_entry_inbound}, 0);
        rst_n = 1'b1;
        send(phit_size'(16'h0201), 1'b0);
        send_load(0, 16, 15, 'hC0);
        @(negedge clk);
        check("t6_counts", {496'd0, num_entry_config_table, num_entry_inbound}, {496'd0, 8'd1, 8'd2});
        check_load("t6_wr", 16, 'hC0);
        check("t6_wait_state", {508'd0, busy, s_tready, start_stream_in, err}, {508'd0, 4'b1000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
